// File: rtl/wb_regfile_writeback_pkg.sv
// Shared write-back package (wb_pkg).
// Holds the architectural register-file geometry and the address/word
// typedefs used by the MEM/WB pipeline register, the forwarding unit and
// the write-back/register-file block.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 32;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // True when the address names an implemented register. This only matters
  // when NUM_REGS is smaller than the address space.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/wb_regfile_writeback_if.sv
// MEM/WB write-back bus.
// Carries the registered write-back fields from the MEM/WB pipeline register
// to the write-back stage.
//   master : driven by the MEM/WB pipeline register
//   slave  : consumed by wb_regfile_writeback
// Handshake: RegWriteIn acts as the valid qualifier for the other fields and
// there is no ready; the consumer accepts a write on every rising Clk edge,
// so the fields are only meaningful in a cycle where RegWriteIn is 1.
interface wb_regfile_writeback_if #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
);

  logic              RegWriteIn;
  logic              MemtoRegIn;
  logic [DATA_W-1:0] ReadDataMemoryIn;
  logic [DATA_W-1:0] ALUResultIn;
  logic [ADDR_W-1:0] DestinationRegisterIn;

  modport master (
    output RegWriteIn,
    output MemtoRegIn,
    output ReadDataMemoryIn,
    output ALUResultIn,
    output DestinationRegisterIn
  );

  modport slave (
    input RegWriteIn,
    input MemtoRegIn,
    input ReadDataMemoryIn,
    input ALUResultIn,
    input DestinationRegisterIn
  );

endinterface

// File: rtl/wb_regfile_writeback_array.sv
// wb_regfile_array: general-purpose register storage.
// One synchronous write port and two independent combinational read ports.
// Register 0 is hard-wired to zero; out-of-range reads return zero.
// Optional macro WB_BYPASS_EN: a read that hits the register being written
// in the same cycle returns the incoming write data (write-before-read).
// Without it, reads return the stored (pre-write) value.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears all entries)
//   we, waddr, wdata  write port; we must already be fully qualified
//   raddr1/rdata1   read port A
//   raddr2/rdata2   read port B
module wb_regfile_array
  import wb_pkg::*;
#(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS,
  parameter int ADDR_W   = wb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ok;

  // Register 0 and unimplemented addresses are never stored, even if the
  // caller forgets to mask them.
  always_comb begin
    wr_ok = we && (waddr != ADDR_W'(ZERO_REG))
               && addr_in_range(int'(waddr), NUM_REGS);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if ((raddr1 != ADDR_W'(ZERO_REG)) && addr_in_range(int'(raddr1), NUM_REGS)) begin
      rdata1 = regs_q[raddr1];
    end
    if ((raddr2 != ADDR_W'(ZERO_REG)) && addr_in_range(int'(raddr2), NUM_REGS)) begin
      rdata2 = regs_q[raddr2];
    end
`ifdef WB_BYPASS_EN
    // wr_ok already excludes register 0, so r0 is never bypassed.
    if (wr_ok && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
    if (wr_ok && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
  end

endmodule

// File: rtl/wb_regfile_writeback.sv
// wb_regfile_writeback: write-back stage plus register file.
// Selects the write-back word (load data or ALU result), commits it to the
// register file, serves the two ID-stage read ports and keeps last-write /
// retired-write debug registers for board display.
// Optional macro WB_BYPASS_EN (see wb_regfile_array): same-cycle
// write-before-read on the read ports.
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   wb (slave)            MEM/WB write-back fields
//   ReadRegister1/2       ID-stage read addresses
//   ReadData1/2           ID-stage read data (combinational)
//   WriteDataOut          selected write-back word (combinational, to forwarding)
//   LastWriteData/Reg     data/destination of the most recent committed write
//   RetiredWrites         committed-write count, wraps modulo 2^CNT_W
module wb_regfile_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS,
  parameter int ADDR_W   = wb_pkg::ADDR_W,
  parameter int CNT_W    = wb_pkg::CNT_W
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  wb_regfile_writeback_if.slave    wb,
  input  logic [ADDR_W-1:0]        ReadRegister1,
  input  logic [ADDR_W-1:0]        ReadRegister2,
  output logic [DATA_W-1:0]        ReadData1,
  output logic [DATA_W-1:0]        ReadData2,
  output logic [DATA_W-1:0]        WriteDataOut,
  output logic [DATA_W-1:0]        LastWriteData,
  output logic [ADDR_W-1:0]        LastWriteReg,
  output logic [CNT_W-1:0]         RetiredWrites
);

  logic              commit;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [ADDR_W-1:0] last_reg_q, last_reg_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  always_comb begin
    WriteDataOut = wb.MemtoRegIn ? wb.ReadDataMemoryIn : wb.ALUResultIn;
  end

  // Reset is part of the commit term so a write presented during reset is
  // neither stored, counted nor bypassed.
  always_comb begin
    commit = Reset_n && wb.RegWriteIn
             && (wb.DestinationRegisterIn != ADDR_W'(ZERO_REG))
             && addr_in_range(int'(wb.DestinationRegisterIn), NUM_REGS);
  end

  wb_regfile_array #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .we     (commit),
    .waddr  (wb.DestinationRegisterIn),
    .wdata  (WriteDataOut),
    .raddr1 (ReadRegister1),
    .raddr2 (ReadRegister2),
    .rdata1 (ReadData1),
    .rdata2 (ReadData2)
  );

  always_comb begin
    last_data_d = last_data_q;
    last_reg_d  = last_reg_q;
    retired_d   = retired_q;
    if (commit) begin
      last_data_d = WriteDataOut;
      last_reg_d  = wb.DestinationRegisterIn;
      retired_d   = retired_q + CNT_W'(1);  // wraps naturally
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      last_data_q <= '0;
      last_reg_q  <= '0;
      retired_q   <= '0;
    end else begin
      last_data_q <= last_data_d;
      last_reg_q  <= last_reg_d;
      retired_q   <= retired_d;
    end
  end

  assign LastWriteData = last_data_q;
  assign LastWriteReg  = last_reg_q;
  assign RetiredWrites = retired_q;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
module tb_wb_regfile_writeback;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2, WriteDataOut, LastWriteData;
  logic [4:0]  LastWriteReg;
  logic [31:0] RetiredWrites;
  logic [31:0] rd1_w4, rd2_w4, wdo_w4, lwd_w4;
  logic [4:0]  lwr_w4;
  logic [3:0]  retired_w4;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_last_data;
  logic [4:0]  mdl_last_reg;
  int unsigned mdl_cnt;

  // scoreboard: expected read-back value per pushed write
  logic [31:0] exp_q[$];
  logic [4:0]  exp_addr_q[$];

  wb_regfile_writeback_if bus ();

  wb_regfile_writeback dut (
    .Clk(Clk), .Reset_n(Reset_n), .wb(bus),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteDataOut(WriteDataOut),
    .LastWriteData(LastWriteData), .LastWriteReg(LastWriteReg),
    .RetiredWrites(RetiredWrites)
  );

  // narrow-counter build fed with the same stimulus, for the wrap check
  wb_regfile_writeback #(.CNT_W(4)) dut_w4 (
    .Clk(Clk), .Reset_n(Reset_n), .wb(bus),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_w4), .ReadData2(rd2_w4), .WriteDataOut(wdo_w4),
    .LastWriteData(lwd_w4), .LastWriteReg(lwr_w4),
    .RetiredWrites(retired_w4)
  );

  // clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then update the model from the inputs that
  // were present at that edge. Returns 1 time unit after the edge.
  task automatic step();
    logic [31:0] wd;
    @(posedge Clk);
    wd = bus.MemtoRegIn ? bus.ReadDataMemoryIn : bus.ALUResultIn;
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
      mdl_last_data = '0;
      mdl_last_reg  = '0;
      mdl_cnt       = 0;
    end else if (bus.RegWriteIn && bus.DestinationRegisterIn != 5'd0) begin
      mdl_regs[bus.DestinationRegisterIn] = wd;
      mdl_last_data = wd;
      mdl_last_reg  = bus.DestinationRegisterIn;
      mdl_cnt       = mdl_cnt + 1;
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.RegWriteIn            = 1'b0;
    bus.MemtoRegIn            = 1'b0;
    bus.ReadDataMemoryIn      = 32'h0;
    bus.ALUResultIn           = 32'h0;
    bus.DestinationRegisterIn = 5'd0;
  endtask

  task automatic drive_write(input logic [4:0] dest, input logic m2r,
                             input logic [31:0] alu, input logic [31:0] mem);
    bus.RegWriteIn            = 1'b1;
    bus.MemtoRegIn            = m2r;
    bus.ALUResultIn           = alu;
    bus.ReadDataMemoryIn      = mem;
    bus.DestinationRegisterIn = dest;
  endtask

  task automatic write_commit(input logic [4:0] dest, input logic m2r,
                              input logic [31:0] alu, input logic [31:0] mem);
    drive_write(dest, m2r, alu, mem);
    step();
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset_n = 1'b0;
    drive_idle();
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    step();
    step();
    Reset_n = 1'b1;
    write_commit(5'd5, 1'b0, 32'hDEADBEEF, 32'h0);
    ReadRegister1 = 5'd5;
    #1;
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_prewrite r5: got %h expected %h", ReadData1, 32'hDEADBEEF);
    end
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5: got %h expected 0", ReadData1);
    end
    checks++;
    if (RetiredWrites !== 32'd0 || retired_w4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d expected 0", RetiredWrites, retired_w4);
    end
    checks++;
    if (LastWriteReg !== 5'd0 || LastWriteData !== 32'h0) begin
      errors++;
      $display("FAIL reset_last: got reg %0d data %h expected 0/0", LastWriteReg, LastWriteData);
    end
  endtask

  task automatic test_select();
    drive_write(5'd3, 1'b0, 32'h00000011, 32'h12345678);
    #1;
    checks++;
    if (WriteDataOut !== 32'h00000011) begin
      errors++;
      $display("FAIL select_alu_wdo: got %h expected %h", WriteDataOut, 32'h11);
    end
    step();
    drive_write(5'd4, 1'b1, 32'h0BADBEEF, 32'hCAFEF00D);
    #1;
    checks++;
    if (WriteDataOut !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL select_mem_wdo: got %h expected %h", WriteDataOut, 32'hCAFEF00D);
    end
    step();
    drive_idle();
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    #1;
    checks++;
    if (ReadData1 !== 32'h00000011) begin
      errors++;
      $display("FAIL select_r3: got %h expected %h", ReadData1, 32'h11);
    end
    checks++;
    if (ReadData2 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL select_r4: got %h expected %h", ReadData2, 32'hCAFEF00D);
    end
    checks++;
    if (RetiredWrites !== 32'd2) begin
      errors++;
      $display("FAIL select_count: got %0d expected 2", RetiredWrites);
    end
    checks++;
    if (LastWriteReg !== 5'd4 || LastWriteData !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL select_last: got reg %0d data %h expected 4/cafef00d", LastWriteReg, LastWriteData);
    end
  endtask

  task automatic test_zero_reg();
    write_commit(5'd0, 1'b0, 32'hFFFFFFFF, 32'h0);
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_read: got %h/%h expected 0/0", ReadData1, ReadData2);
    end
    checks++;
    if (RetiredWrites !== 32'd2) begin
      errors++;
      $display("FAIL zero_reg_count: got %0d expected 2", RetiredWrites);
    end
    checks++;
    if (LastWriteReg !== 5'd4 || LastWriteData !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL zero_reg_last: got reg %0d data %h expected 4/cafef00d", LastWriteReg, LastWriteData);
    end
  endtask

  task automatic test_no_write();
    drive_write(5'd3, 1'b1, 32'hAAAA5555, 32'h5555AAAA);
    bus.RegWriteIn = 1'b0;
    step();
    drive_idle();
    ReadRegister1 = 5'd3;
    #1;
    checks++;
    if (ReadData1 !== 32'h00000011 || RetiredWrites !== 32'd2 || LastWriteReg !== 5'd4) begin
      errors++;
      $display("FAIL no_write: got r3 %h count %0d last %0d expected 11/2/4", ReadData1, RetiredWrites, LastWriteReg);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_same;
`ifdef WB_BYPASS_EN
    exp_same = 32'h2;
`else
    exp_same = 32'h1;
`endif
    write_commit(5'd7, 1'b0, 32'h1, 32'h0);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    drive_write(5'd7, 1'b0, 32'h2, 32'h0);
    #1;
    checks++;
    if (ReadData1 !== exp_same || ReadData2 !== exp_same) begin
      errors++;
      $display("FAIL collision_same_cycle: got %h/%h expected %h", ReadData1, ReadData2, exp_same);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if (ReadData1 !== 32'h2 || ReadData2 !== 32'h2) begin
      errors++;
      $display("FAIL collision_next: got %h/%h expected 2", ReadData1, ReadData2);
    end
    // r0 must never bypass
    ReadRegister1 = 5'd0;
    drive_write(5'd0, 1'b0, 32'h77, 32'h0);
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL collision_r0: got %h expected 0", ReadData1);
    end
    step();
    drive_idle();
  endtask

  task automatic test_reset_vs_write();
    ReadRegister1 = 5'd9;
    Reset_n = 1'b0;
    drive_write(5'd9, 1'b0, 32'h55, 32'h0);
    #1;
    checks++;
    if (ReadData1 !== mdl_regs[9]) begin
      errors++;
      $display("FAIL reset_write_no_bypass: got %h expected %h", ReadData1, mdl_regs[9]);
    end
    step();
    Reset_n = 1'b1;
    drive_idle();
    #1;
    checks++;
    if (ReadData1 !== 32'h0 || RetiredWrites !== 32'd0) begin
      errors++;
      $display("FAIL reset_write_dropped: got r9 %h count %0d expected 0/0", ReadData1, RetiredWrites);
    end
    write_commit(5'd9, 1'b0, 32'h66, 32'h0);
    #1;
    checks++;
    if (ReadData1 !== 32'h66 || RetiredWrites !== 32'd1) begin
      errors++;
      $display("FAIL reset_write_after: got r9 %h count %0d expected 66/1", ReadData1, RetiredWrites);
    end
  endtask

  task automatic test_wrap();
    Reset_n = 1'b0;
    drive_idle();
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      write_commit(5'($urandom_range(31, 1)), 1'b0, $urandom, 32'h0);
      step();  // idle cycle must not count
      if (i == 14) begin
        checks++;
        if (retired_w4 !== 4'd15 || RetiredWrites !== 32'd15) begin
          errors++;
          $display("FAIL wrap_15: got %0d/%0d expected 15/15", retired_w4, RetiredWrites);
        end
      end
    end
    checks++;
    if (retired_w4 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", retired_w4);
    end
    checks++;
    if (RetiredWrites !== 32'd16) begin
      errors++;
      $display("FAIL wrap_wide: got %0d expected 16", RetiredWrites);
    end
  endtask

  task automatic test_random();
    logic [4:0]  dest, a, other;
    logic        m2r;
    logic [31:0] alu, mem, exp_v;
    for (int i = 0; i < 40; i++) begin
      dest = 5'($urandom_range(31, 0));
      m2r  = 1'($urandom_range(1, 0));
      alu  = $urandom;
      mem  = $urandom;
      exp_v = (dest == 5'd0) ? 32'h0 : (m2r ? mem : alu);
      exp_q.push_back(exp_v);
      exp_addr_q.push_back(dest);
      if ($urandom_range(3, 0) == 0) begin
        drive_write(dest, m2r, alu, mem);
        bus.RegWriteIn = 1'b0;
        exp_q[$size(exp_q)-1] = mdl_regs[dest];
        step();
        drive_idle();
      end else begin
        write_commit(dest, m2r, alu, mem);
      end
      a     = exp_addr_q.pop_front();
      exp_v = exp_q.pop_front();
      other = 5'($urandom_range(31, 0));
      ReadRegister1 = a;
      ReadRegister2 = other;
      #1;
      checks++;
      if (ReadData1 !== exp_v) begin
        errors++;
        $display("FAIL random_readback r%0d: got %h expected %h", a, ReadData1, exp_v);
      end
      checks++;
      if (ReadData2 !== mdl_regs[other]) begin
        errors++;
        $display("FAIL random_port2 r%0d: got %h expected %h", other, ReadData2, mdl_regs[other]);
      end
      checks++;
      if (RetiredWrites !== 32'(mdl_cnt) || retired_w4 !== mdl_cnt[3:0] ||
          LastWriteReg !== mdl_last_reg || LastWriteData !== mdl_last_data) begin
        errors++;
        $display("FAIL random_debug: got cnt %0d/%0d last %0d %h expected %0d last %0d %h",
                 RetiredWrites, retired_w4, LastWriteReg, LastWriteData,
                 mdl_cnt, mdl_last_reg, mdl_last_data);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
    mdl_last_data = '0;
    mdl_last_reg  = '0;
    mdl_cnt       = 0;
    test_reset();
    test_select();
    test_zero_reg();
    test_no_write();
    test_collision();
    test_reset_vs_write();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
